// File: rtl/cpu_fpu_mul.sv
// ---------------------------------------------------------------------------
// cpu_fpu_mul
//   Multi-cycle IEEE-754 single-precision multiplier for the CPU FPU.
//   Round-to-nearest-even, with denormal inputs and gradual-underflow outputs.
//   Shares the request/ready handshake used by the FPU divider.
//
// Parameters
//   STEP_BITS  multiplier bits consumed per MUL cycle (1,2,3,4,6,8,12,24);
//              the shift-add loop takes 24/STEP_BITS cycles.
//
// Ports
//   i_clock    clock, rising edge
//   i_reset    asynchronous, active-high reset
//   i_request  level request; operands valid while high
//   i_op1      operand A (IEEE-754 single)
//   i_op2      operand B (IEEE-754 single)
//   o_ready    result valid (registered); held while i_request stays high
//   o_result   product (registered)
// ---------------------------------------------------------------------------
module cpu_fpu_mul #(
    parameter int STEP_BITS = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    output logic        o_ready,
    output logic [31:0] o_result
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SPECIAL,
        ST_NORM_A,
        ST_NORM_B,
        ST_MUL_INIT,
        ST_MUL,
        ST_EXTRACT,
        ST_NORM,
        ST_DENORM,
        ST_ROUND,
        ST_PACK,
        ST_DONE
    } state_t;

    localparam int               N_STEPS   = 24 / STEP_BITS;
    localparam logic [4:0]       LAST_STEP = 5'(N_STEPS - 1);
    localparam logic signed [9:0] E_SPECIAL = 10'sd128;   // inf / NaN field
    localparam logic signed [9:0] E_DENORM  = -10'sd127;  // zero / denormal field
    localparam logic signed [9:0] E_MIN     = -10'sd126;  // smallest normal exponent
    localparam logic signed [9:0] E_MAX     = 10'sd127;
    localparam logic [31:0]       QNAN      = 32'hFFC0_0000;

    state_t state_q, state_d;

    // Unpacked operands; mantissa carries the hidden bit in [23].
    logic [23:0]        a_m, b_m;
    logic signed [9:0]  a_e, b_e;
    logic               a_s, b_s;

    // Product path.
    logic [47:0]        prod;       // shift-add accumulator
    logic [47:0]        mcand;      // b_m aligned to the current digit
    logic [4:0]         step_cnt;
    logic [23:0]        z_m;
    logic signed [9:0]  z_e;
    logic               z_s;
    logic               guard, round_bit, sticky;
    logic [31:0]        pack_q;     // packed result waiting for DONE

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_special;
    logic [47:0] digit;

    // Classification is done on the raw fields before the hidden bit is set.
    assign a_nan  = (a_e == E_SPECIAL) && (a_m != 24'd0);
    assign b_nan  = (b_e == E_SPECIAL) && (b_m != 24'd0);
    assign a_inf  = (a_e == E_SPECIAL) && (a_m == 24'd0);
    assign b_inf  = (b_e == E_SPECIAL) && (b_m == 24'd0);
    assign a_zero = (a_e == E_DENORM)  && (a_m == 24'd0);
    assign b_zero = (b_e == E_DENORM)  && (b_m == 24'd0);
    assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    // a_m is shifted right as digits are consumed, so the low bits are always
    // the next digit.
    assign digit = 48'(a_m[STEP_BITS-1:0]);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_d is assigned a default before the case so every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (i_request) state_d = ST_SPECIAL;
            ST_SPECIAL:  state_d = is_special ? ST_DONE : ST_NORM_A;
            ST_NORM_A:   if (a_m[23]) state_d = ST_NORM_B;
            ST_NORM_B:   if (b_m[23]) state_d = ST_MUL_INIT;
            ST_MUL_INIT: state_d = ST_MUL;
            ST_MUL:      if (step_cnt == LAST_STEP) state_d = ST_EXTRACT;
            ST_EXTRACT:  state_d = ST_NORM;
            ST_NORM:     if (z_m[23] || (z_e <= E_MIN)) state_d = ST_DENORM;
            ST_DENORM:   if (z_e >= E_MIN) state_d = ST_ROUND;
            ST_ROUND:    state_d = ST_PACK;
            ST_PACK:     state_d = ST_DONE;
            ST_DONE:     if (!i_request) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control state and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            o_ready  <= 1'b0;
            o_result <= 32'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_DONE) && i_request) begin
                o_ready  <= 1'b1;
                o_result <= pack_q;
            end else begin
                o_ready  <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    // NOTE: datapath registers carry no reset; every one is loaded before it
    // is read on the way from IDLE to DONE, and reset only returns the FSM.
    always_ff @(posedge i_clock) begin
        case (state_q)
            ST_IDLE: begin
                if (i_request) begin
                    a_s <= i_op1[31];
                    a_e <= $signed({2'b00, i_op1[30:23]}) - 10'sd127;
                    a_m <= {1'b0, i_op1[22:0]};
                    b_s <= i_op2[31];
                    b_e <= $signed({2'b00, i_op2[30:23]}) - 10'sd127;
                    b_m <= {1'b0, i_op2[22:0]};
                end
            end

            ST_SPECIAL: begin
                if (is_special) begin
                    if (a_nan || b_nan)
                        pack_q <= QNAN;
                    else if ((a_inf && b_zero) || (a_zero && b_inf))
                        pack_q <= QNAN;
                    else if (a_inf || b_inf)
                        pack_q <= {a_s ^ b_s, 8'hFF, 23'd0};
                    else
                        pack_q <= {a_s ^ b_s, 31'd0};
                end else begin
                    // Denormals use the minimum exponent with no hidden bit.
                    if (a_e == E_DENORM) a_e <= E_MIN;
                    else                 a_m[23] <= 1'b1;
                    if (b_e == E_DENORM) b_e <= E_MIN;
                    else                 b_m[23] <= 1'b1;
                end
            end

            ST_NORM_A: begin
                if (!a_m[23]) begin
                    a_m <= a_m << 1;
                    a_e <= a_e - 10'sd1;
                end
            end

            ST_NORM_B: begin
                if (!b_m[23]) begin
                    b_m <= b_m << 1;
                    b_e <= b_e - 10'sd1;
                end
            end

            ST_MUL_INIT: begin
                z_s      <= a_s ^ b_s;
                // +1 because z_m is taken from p[47:24], one bit above 1.0.
                z_e      <= a_e + b_e + 10'sd1;
                prod     <= 48'd0;
                mcand    <= {24'd0, b_m};
                step_cnt <= 5'd0;
            end

            ST_MUL: begin
                prod     <= prod + mcand * digit;
                mcand    <= mcand << STEP_BITS;
                a_m      <= a_m >> STEP_BITS;
                step_cnt <= step_cnt + 5'd1;
            end

            ST_EXTRACT: begin
                z_m       <= prod[47:24];
                guard     <= prod[23];
                round_bit <= prod[22];
                sticky    <= |prod[21:0];
            end

            ST_NORM: begin
                if (!z_m[23] && (z_e > E_MIN)) begin
                    z_m       <= {z_m[22:0], guard};
                    guard     <= round_bit;
                    round_bit <= 1'b0;
                    z_e       <= z_e - 10'sd1;
                end
            end

            ST_DENORM: begin
                if (z_e < E_MIN) begin
                    z_m       <= z_m >> 1;
                    guard     <= z_m[0];
                    round_bit <= guard;
                    sticky    <= sticky | round_bit;
                    z_e       <= z_e + 10'sd1;
                end
            end

            ST_ROUND: begin
                if (guard && (round_bit || sticky || z_m[0])) begin
                    z_m <= z_m + 24'd1;
                    // Mantissa wraps to 1.0 of the next binade.
                    if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
                end
            end

            ST_PACK: begin
                if (z_e > E_MAX)
                    pack_q <= {z_s, 8'hFF, 23'd0};
                else if ((z_e == E_MIN) && !z_m[23])
                    pack_q <= {z_s, 8'h00, z_m[22:0]};
                else
                    pack_q <= {z_s, z_e[7:0] + 8'd127, z_m[22:0]};
            end

            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_fpu_mul.sv
// ---------------------------------------------------------------------------
// tb_cpu_fpu_mul
//   Directed self-checking bench for cpu_fpu_mul (STEP_BITS = 4, N = 6).
//   Latency is counted in rising edges after the accept edge: 10+N for
//   normalized operands, plus one per normalisation/denormalisation shift.
//   A product of mantissas below 2.0 (e.g. 1.0*1.5) needs one NORM shift.
// ---------------------------------------------------------------------------
module tb_cpu_fpu_mul;

    localparam int STEP_BITS = 4;
    localparam int N_STEPS   = 24 / STEP_BITS;
    localparam int BASE_LAT  = 10 + N_STEPS;
    localparam int SPEC_LAT  = 2;
    localparam int MAX_WAIT  = 400;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_request;
    logic [31:0] i_op1, i_op2;
    logic        o_ready;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    cpu_fpu_mul #(.STEP_BITS(STEP_BITS)) dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_request(i_request),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .o_ready  (o_ready),
        .o_result (o_result)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Present operands, count edges from accept to o_ready, and check the
    // latency, the result, an optional hold period, and the drop.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input int hold);
        int lat;
        @(negedge i_clock);
        i_op1     = a;
        i_op2     = b;
        i_request = 1'b1;
        @(posedge i_clock);            // accept edge
        lat = 0;
        do begin
            @(posedge i_clock);
            #1;
            lat++;
        end while (!o_ready && lat < MAX_WAIT);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, o_result, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clock);
            #1;
            check({tag, " hold ready"}, {31'd0, o_ready}, 32'd1);
            check({tag, " hold result"}, o_result, exp_res);
        end
        @(negedge i_clock);
        i_request = 1'b0;
        @(posedge i_clock);
        #1;
        check({tag, " drop ready"}, {31'd0, o_ready}, 32'd0);
    endtask

    initial begin
        i_reset   = 1'b1;
        i_request = 1'b0;
        i_op1     = 32'd0;
        i_op2     = 32'd0;
        #1;
        check("reset ready", {31'd0, o_ready}, 32'd0);
        check("reset result", o_result, 32'd0);
        repeat (2) @(negedge i_clock);
        i_reset = 1'b0;

        // Main function.
        run_op("2*3",         32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, BASE_LAT + 1, 5);
        run_op("1.5*-2.5",    32'h3FC0_0000, 32'hC020_0000, 32'hC070_0000, BASE_LAT + 1, 0);

        // Reset mid-MUL: outputs clear at once, no result appears afterwards.
        @(negedge i_clock);
        i_op1     = 32'h4000_0000;
        i_op2     = 32'h4040_0000;
        i_request = 1'b1;
        @(posedge i_clock);            // accept
        repeat (6) @(posedge i_clock); // inside MUL
        #2;
        i_reset = 1'b1;
        #1;
        check("async reset ready", {31'd0, o_ready}, 32'd0);
        check("async reset result", o_result, 32'd0);
        @(negedge i_clock);
        i_request = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b0;
        repeat (3) @(posedge i_clock);
        #1;
        check("post reset ready", {31'd0, o_ready}, 32'd0);
        check("post reset result", o_result, 32'd0);
        run_op("2*2 after reset", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, BASE_LAT + 1, 0);

        // Rounding with sticky bits only.
        run_op("rne sticky",  32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, BASE_LAT + 1, 0);

        // Special cases.
        run_op("inf*0",       32'h7F80_0000, 32'h0000_0000, 32'hFFC0_0000, SPEC_LAT, 0);
        run_op("nan*1",       32'h7FC0_0000, 32'h3F80_0000, 32'hFFC0_0000, SPEC_LAT, 0);
        run_op("-inf*2",      32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, SPEC_LAT, 0);
        run_op("-0*1",        32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, SPEC_LAT, 0);

        // Overflow and underflow.
        run_op("overflow",    32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, BASE_LAT + 1, 0);
        run_op("denorm out",  32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, BASE_LAT, 0);
        // 23 NORM_A shifts and 23 DENORM shifts.
        run_op("tie to even", 32'h0000_0001, 32'h3F00_0000, 32'h0000_0000, BASE_LAT + 46, 0);

        // Re-raise after a drop: fresh result at full latency, never the old one.
        run_op("reraise",     32'h3FC0_0000, 32'hC020_0000, 32'hC070_0000, BASE_LAT + 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
